// File: rtl/register_file_bypass.sv
`default_nettype none
// ============================================================================
// register_file_bypass : multi-read-port register file with byte-lane writes,
// optional write-to-read bypass and a per-register busy scoreboard. Rev 1.0
// ============================================================================
module register_file_bypass #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*AW-1:0]     raddr,
  output logic [NR*XLEN-1:0]   rdata,
  output logic [NR-1:0]        rbusy,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN/8-1:0]    wbe,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd
);

  localparam int DEPTH = 2**AW;
  localparam int NB    = XLEN/8;

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [XLEN-1:0]  wmask;
  logic [XLEN-1:0]  wmerged;
  logic             wr_en;
  logic             iss_en;

  assign wr_en  = we && (waddr != '0);
  assign iss_en = issue_valid && (issue_rd != '0);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{wbe[b]}};
    end
  end

  // Shared by the storage update and the bypass path: old word with enabled lanes replaced.
  assign wmerged = (regs[waddr] & ~wmask) | (wdata & wmask);

  // Clear before set so a same-edge issue to the written register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[waddr]    = 1'b0;
    if (iss_en) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      busy <= busy_nxt;
      if (wr_en) begin
        regs[waddr] <= wmerged;
      end
    end
  end

  generate
    for (genvar i = 0; i < NR; i++) begin : g_read
      logic [AW-1:0]   a;
      logic            hit;
      logic [XLEN-1:0] rd;
      logic            bz;

      assign a = raddr[i*AW +: AW];
      // Bypass is suppressed in reset so every port reads zero while rst is high.
      assign hit = (BYPASS != 0) && !rst && wr_en && (waddr == a);

      always_comb begin
        rd = '0;
        bz = 1'b0;
        if (a != '0) begin
          if (hit) begin
            rd = wmerged;
          end else begin
            rd = regs[a];
            bz = busy[a];
          end
        end
      end

      assign rdata[i*XLEN +: XLEN] = rd;
      assign rbusy[i]              = bz;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_register_file_bypass.sv
`default_nettype none
// ============================================================================
// tb_register_file_bypass : directed plus randomized checks of both bypass
// variants against an array-based model of the register file. Rev 1.0
// ============================================================================
module tb_register_file_bypass;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NR   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NR*AW-1:0]   raddr = '0;
  logic [NR*XLEN-1:0] rdata;
  logic [NR-1:0]      rbusy;
  logic               we = 1'b0;
  logic [AW-1:0]      waddr = '0;
  logic [XLEN-1:0]    wdata = '0;
  logic [3:0]         wbe = '0;
  logic               issue_valid = 1'b0;
  logic [AW-1:0]      issue_rd = '0;
  logic [XLEN-1:0]    rdata_nb;
  logic [0:0]         rbusy_nb;

  int checks = 0;
  int errors = 0;

  bit [31:0] mem    [32];
  bit        busy_m [32];

  register_file_bypass #(.XLEN(XLEN), .AW(AW), .NR(NR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  register_file_bypass #(.XLEN(XLEN), .AW(AW), .NR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr[AW-1:0]), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] d, bit [3:0] be);
    bit [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: register array and busy flags updated from the spec rules.
  always @(posedge rst) begin
    for (int r = 0; r < 32; r++) begin
      mem[r]    = '0;
      busy_m[r] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (we && waddr != 0) begin
        mem[waddr]    = merge(mem[waddr], wdata, wbe);
        busy_m[waddr] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    end
  end

  // Every negedge: all ports of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      int        a;
      bit [31:0] ed;
      bit        eb;
      a = int'(raddr[i*AW +: AW]);
      if (rst || a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (we && int'(waddr) == a) begin
        ed = merge(mem[a], wdata, wbe); eb = 1'b0;
      end else begin
        ed = mem[a]; eb = busy_m[a];
      end
      check($sformatf("model rdata[%0d] a=%0d", i, a), rdata[i*XLEN +: XLEN], ed);
      check($sformatf("model rbusy[%0d] a=%0d", i, a), {31'd0, rbusy[i]}, {31'd0, eb});
    end
    begin
      int a;
      a = int'(raddr[AW-1:0]);
      check("model nb rdata", rdata_nb, (rst || a == 0) ? 32'd0 : mem[a]);
      check("model nb rbusy", {31'd0, rbusy_nb}, (rst || a == 0) ? 32'd0 : {31'd0, busy_m[a]});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic write(input int a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = AW'(a); wdata = d; wbe = be;
    next_cycle();
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    raddr = {5'd3, 5'd2, 5'd1, 5'd5};
    @(negedge clk);
    check("reset rdata0", rdata[31:0], 32'h0);
    check("reset rbusy", {28'd0, rbusy}, 32'h0);
    next_cycle();
    rst = 1'b0;

    // x0 is hardwired
    raddr = '0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    check("x0 same cycle rdata", rdata[127:96] | rdata[95:64] | rdata[63:32] | rdata[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("x0 after rdata", rdata[31:0], 32'h0);
    check("x0 after rbusy", {28'd0, rbusy}, 32'h0);

    // Byte lanes
    next_cycle();
    write(3, 32'h1122_3344, 4'hF);
    write(3, 32'hAABB_CCDD, 4'b0101);
    raddr = {5'd0, 5'd0, 5'd3, 5'd3};
    @(negedge clk);
    check("byte lanes rdata1", rdata[63:32], 32'h11BB_33DD);
    check("byte lanes nb", rdata_nb, 32'h11BB_33DD);

    // Bypass vs stored-only
    next_cycle();
    raddr = {5'd0, 5'd0, 5'd0, 5'd7};
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; wbe = 4'hF;
    @(negedge clk);
    check("bypass same cycle", rdata[31:0], 32'h1234_5678);
    check("nobypass same cycle", rdata_nb, 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("nobypass next cycle", rdata_nb, 32'h1234_5678);

    // Scoreboard
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    next_cycle();
    idle();
    raddr = {5'd0, 5'd0, 5'd0, 5'd9};
    @(negedge clk);
    check("busy cycle2", {31'd0, rbusy[0]}, 32'd1);
    next_cycle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h55; wbe = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    check("busy cycle3 nb", {31'd0, rbusy_nb}, 32'd1);
    check("busy cycle3 bypass hit", {31'd0, rbusy[0]}, 32'd0);
    next_cycle();
    idle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h66; wbe = 4'hF;
    @(negedge clk);
    check("set wins nb", {31'd0, rbusy_nb}, 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("cleared cycle5", {31'd0, rbusy[0]}, 32'd0);
    check("cleared cycle5 nb", {31'd0, rbusy_nb}, 32'd0);

    // Multi-port
    next_cycle();
    for (int k = 1; k <= 4; k++) write(k, 32'(k), 4'hF);
    raddr = {5'd1, 5'd2, 5'd3, 5'd4};
    @(negedge clk);
    check("multiport p3", rdata[127:96], 32'h1);
    check("multiport p2", rdata[95:64],  32'h2);
    check("multiport p1", rdata[63:32],  32'h3);
    check("multiport p0", rdata[31:0],   32'h4);

    // Reset arriving mid-cycle with a write and issue pending
    next_cycle();
    write(5, 32'hDEAD_BEEF, 4'hF);
    raddr = {5'd5, 5'd5, 5'd9, 5'd5};
    issue_valid = 1'b1; issue_rd = 5'd5;
    next_cycle();
    we = 1'b1; waddr = 5'd6; wdata = 32'hCAFE_F00D; wbe = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd6;
    @(negedge clk);
    check("pre-reset x5", rdata[31:0], 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check("mid reset x5", rdata[31:0], 32'h0);
    check("mid reset rbusy", {28'd0, rbusy}, 32'h0);
    raddr = {5'd6, 5'd6, 5'd6, 5'd6};
    #1;
    check("mid reset bypass blocked", rdata[31:0], 32'h0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post reset x6", rdata[31:0], 32'h0);
    check("post reset rbusy", {28'd0, rbusy}, 32'h0);

    // Randomized traffic, occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
      end
      we          = ($urandom_range(1) == 1);
      waddr       = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
      wdata       = $urandom;
      wbe         = 4'($urandom);
      issue_valid = ($urandom_range(2) == 0);
      issue_rd    = 5'($urandom_range(7));
      for (int i = 0; i < NR; i++) begin
        raddr[i*AW +: AW] = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
      end
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_bypass.md
# register_file_bypass

Parametrised successor to the core's single-write, dual-read register file. It adds:
- a configurable number of read ports;
- byte-lane write enables;
- optional write-to-read bypass;
- a per-register busy scoreboard for hazard detection.

It sits between decode (read/issue) and writeback. Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8
- AW, 5, address width; DEPTH = 2**AW registers
- NR, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the stored value only

Ports. Clocking is one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- raddr  in  NR*AW  read addresses; port i occupies bits [i*AW +: AW]
- rdata  out  NR*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rbusy  out  NR  busy flag for each read port's register
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- wbe  in  XLEN/8  byte-lane enables; bit b controls wdata[8b+7:8b]
- issue_valid  in  1  an instruction issues that will write issue_rd
- issue_rd  in  AW  destination register of the issuing instruction

## Operation
Storage:
- DEPTH x XLEN register array plus a DEPTH-bit busy vector.
- Entry 0 is never written. It always reads 0 and is never busy.

Write:
- On a rising edge with we=1 and waddr!=0, each byte b with wbe[b]=1 takes wdata byte b.
- Bytes with wbe[b]=0 keep their value.
- we=1 with wbe=0 changes no data but still clears busy (see below).

Read (combinational, per port i, address a = raddr[i]):
- a==0: rdata=0, rbusy=0.
- Bypass hit: BYPASS=1, we=1, waddr==a, a!=0.
  - rdata = stored[a] with the enabled bytes replaced by wdata.
  - rbusy[i]=0.
- Otherwise: rdata = stored[a], rbusy[i] = busy[a].
- All NR ports are independent. Any number of ports may read the same address.

Scoreboard (at the rising edge):
- issue_valid=1 and issue_rd!=0: busy[issue_rd] is set.
- we=1 and waddr!=0: busy[waddr] is cleared.
- Both events in the same edge on the same register: the set wins, because the new producer is outstanding.
- Both events on different registers: both take effect.
- issue_rd==0 or waddr==0: no busy change.

Reset:
- rst=1 asynchronously clears all registers and all busy bits, regardless of clk.
- While rst=1, we and issue_valid are ignored.
- rdata ports read 0 for every address while in reset and after release until written.
- rbusy is 0 while in reset and after release until a register is issued.
- Reset arriving mid-sequence discards any pending write or issue in that cycle.

## Timing
- Read latency is 0 cycles (combinational from raddr, and from we/waddr/wdata/wbe when BYPASS=1).
- Write latency is 1 edge:
  - BYPASS=0: the value is visible on reads in the cycle after the edge.
  - BYPASS=1: the value is visible in the same cycle it is presented.
- Busy set by issue at edge N: rbusy is visible from cycle N+1.
- Busy clear by write at edge N: visible from cycle N+1, or immediately through a bypass hit when BYPASS=1.
- No handshake. Callers must not drive X on we or issue_valid. Addresses are don't-care when their enables are 0.
- Reset release must be synchronous to clk; the block does not synchronise rst.

## Test plan
- Reset:
  - Stimulus: write 0xDEADBEEF to x5, then assert rst mid-cycle.
  - Required: rdata for x5 is 0 immediately, before the next edge. rbusy is 0 on all ports.
- x0:
  - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF, wbe=0xF; issue_valid=1, issue_rd=0.
  - Required: reading x0 on every port gives 0, rbusy=0.
- Byte lanes:
  - Stimulus: x3=0x11223344, then write wdata=0xAABBCCDD with wbe=0b0101.
  - Required: x3 reads 0x11BB33DD on the next cycle.
- Bypass (BYPASS=1):
  - Stimulus: x7=0; same cycle drive raddr port0=7, we=1, waddr=7, wdata=0x12345678, wbe=0xF.
  - Required: rdata0=0x12345678 that cycle.
  - With BYPASS=0: rdata0=0 that cycle and 0x12345678 the next.
- Scoreboard:
  - Stimulus: issue x9 at edge 1.
  - Required: rbusy for x9 is 1 in cycles 2..3.
  - Then write x9 at edge 3 together with issue x9 at edge 3: x9 stays busy.
  - Then write x9 at edge 4 with no issue: rbusy=0 from cycle 5.
- Multi-port (NR=4):
  - Stimulus: x1..x4 = 0x1..0x4; read addresses 4,3,2,1 in one cycle.
  - Required: rdata = {0x1,0x2,0x3,0x4} in port 3..0 order, with no port interference.
